// File: rtl/safe_sync_seq_pkg.sv
// Shared types and defaults for the dual-core resynchronisation sequencer.
// Holds the FSM state encoding and a small helper used to size the shared counter.
package safe_sync_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PEER = 3'd1,
    WAIT_ACK  = 3'd2,
    HALT      = 3'd3,
    RELEASE   = 3'd4,
    ERROR     = 3'd5
  } sync_state_e;

  localparam int unsigned DefTimeoutCycles = 1024;
  localparam int unsigned DefHaltCycles    = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/safe_sync_edge_det.sv
// Per-bit rising-edge detector with asynchronous active-high clear.
// Edges are suppressed until one sample has been taken after reset, so a level
// that is already high at reset release is not mistaken for a new request.
module safe_sync_edge_det #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] prev_q;
  logic             primed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= d_i;
      primed_q <= 1'b1;
    end
  end

  assign rise_o = d_i & ~prev_q & {Width{primed_q}};

endmodule

// File: rtl/safe_sync_seq.sv
// Dual-core resynchronisation sequencer: interrupt the lagging core, wait for the
// software acknowledge, halt both cores for a fixed window, then release.
module safe_sync_seq
  import safe_sync_seq_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  parameter int unsigned HaltCycles    = DefHaltCycles
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       core0sync_i,
  input  logic       core1sync_i,
  input  logic       intc_ack_i,
  input  logic       err_clr_i,
  output logic [1:0] intc_o,
  output logic [1:0] debug_req_o,
  output logic       sync_done_o,
  output logic       busy_o,
  output logic       timeout_err_o
);

  localparam int unsigned CntWidth = $clog2(max_u(TimeoutCycles, HaltCycles) + 1);
  localparam logic [CntWidth-1:0] CntMax      = '1;
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] HaltLast    = CntWidth'(HaltCycles - 1);

  sync_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic                init_q, init_d;
  logic [1:0]          sync, rise;
  logic [1:0]          intc_d, dbg_d;
  logic                done_d, busy_d, err_d;

  assign sync = {core1sync_i, core0sync_i};

  safe_sync_edge_det #(.Width(2)) u_edge_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (sync),
    .rise_o (rise)
  );

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    case (state_q)
      IDLE: begin
        if (&sync) begin
          state_d = WAIT_ACK;
        end else if (^rise) begin
          state_d = WAIT_PEER;
          cnt_d   = '0;
          init_d  = rise[1];
        end
      end
      // Peer arrival is tested before expiry so a same-cycle arrival wins.
      WAIT_PEER: begin
        if (&sync) begin
          state_d = WAIT_ACK;
        end else if (!sync[init_q]) begin
          state_d = IDLE;
        end else if (cnt_q == TimeoutLast) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_ACK: begin
        if (intc_ack_i) begin
          state_d = HALT;
          cnt_d   = '0;
        end
      end
      HALT: begin
        if (cnt_q == HaltLast) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (!(|sync) && !intc_ack_i) begin
          state_d = IDLE;
        end
      end
      ERROR:   state_d = RELEASE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    intc_d = (state_d == WAIT_PEER) ? ~sync : 2'b00;
    dbg_d  = (state_d == HALT) ? 2'b11 : 2'b00;
    done_d = (state_q == HALT) && (state_d == RELEASE);
    busy_d = (state_d != IDLE);
    err_d  = timeout_err_o;
    if (state_d == ERROR) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      init_q        <= 1'b0;
      intc_o        <= 2'b00;
      debug_req_o   <= 2'b00;
      sync_done_o   <= 1'b0;
      busy_o        <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_q        <= init_d;
      intc_o        <= intc_d;
      debug_req_o   <= dbg_d;
      sync_done_o   <= done_d;
      busy_o        <= busy_d;
      timeout_err_o <= err_d;
    end
  end

endmodule

// File: tb/tb_safe_sync_seq.sv
// Self-checking bench for safe_sync_seq with TimeoutCycles=8, HaltCycles=4.
// Outputs are packed as {intc[1:0], debug_req[1:0], sync_done, busy, timeout_err}.
module tb_safe_sync_seq;

  localparam int unsigned Timeout = 8;
  localparam int unsigned Halt    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       core0 = 1'b1, core1 = 1'b1, ack = 1'b1, clr = 1'b0;
  logic [1:0] intc, dbg;
  logic       done, busy, err;
  logic [6:0] obs;

  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  safe_sync_seq #(.TimeoutCycles(Timeout), .HaltCycles(Halt)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core0sync_i   (core0),
    .core1sync_i   (core1),
    .intc_ack_i    (ack),
    .err_clr_i     (clr),
    .intc_o        (intc),
    .debug_req_o   (dbg),
    .sync_done_o   (done),
    .busy_o        (busy),
    .timeout_err_o (err)
  );

  assign obs = {intc, dbg, done, busy, err};

  function automatic logic [6:0] e(input logic [1:0] i, input logic [1:0] d,
                                   input logic dn, input logic b, input logic er);
    return {i, d, dn, b, er};
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%b exp=%b", tag, got, want);
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input string tag, input logic c0, input logic c1,
                      input logic a, input logic cl, input logic [6:0] want);
    @(negedge clk);
    core0 = c0; core1 = c1; ack = a; clr = cl;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic idle(input int n, input logic er);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b0, er));
  endtask

  // From WAIT_ACK: acknowledge, halt window, done pulse, then drop everything.
  task automatic halt_release();
    step("halt_first", 1'b1, 1'b1, 1'b1, 1'b0, e(2'b00, 2'b11, 1'b0, 1'b1, 1'b0));
    for (int i = 1; i < int'(Halt); i++)
      step("halt_hold", 1'b0, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b11, 1'b0, 1'b1, 1'b0));
    step("done_pulse", 1'b1, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b1, 1'b1, 1'b0));
    step("rel_stale",  1'b1, 1'b0, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    step("rel_ack",    1'b0, 1'b0, 1'b1, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    step("rel_idle",   1'b0, 1'b0, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    // Reset held with all inputs high.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(7'd0);
      @(posedge clk);
      #1;
      chk("in_reset", obs, exp_q.pop_front());
    end
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_both_high", obs, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    halt_release();
    idle($urandom_range(1, 4), 1'b0);

    // Normal flow: core0 first, core1 later.
    step("c0_rise", 1'b1, 1'b0, 1'b0, 1'b0, e(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++)
      step("c0_wait", 1'b1, 1'b0, 1'b0, 1'b0, e(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
    step("c1_join", 1'b1, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    step("wait_ack", 1'b1, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    halt_release();
    idle($urandom_range(1, 4), 1'b0);

    // Simultaneous request never raises intc.
    step("both_rise", 1'b1, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    halt_release();
    idle($urandom_range(1, 4), 1'b0);

    // Timeout on core1 alone; clear in the set cycle loses to the set.
    step("c1_rise", 1'b0, 1'b1, 1'b0, 1'b0, e(2'b01, 2'b00, 1'b0, 1'b1, 1'b0));
    for (int i = 1; i < int'(Timeout); i++)
      step("c1_wait", 1'b0, 1'b1, 1'b0, 1'b0, e(2'b01, 2'b00, 1'b0, 1'b1, 1'b0));
    step("to_set_vs_clr", 1'b0, 1'b1, 1'b0, 1'b1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
    step("to_release",    1'b0, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
    step("to_rel_hold",   1'b0, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
    step("to_idle_sticky",1'b0, 1'b0, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
    idle($urandom_range(1, 3), 1'b1);
    step("err_clr",       1'b0, 1'b0, 1'b0, 1'b1, e(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    idle(1, 1'b0);

    // Peer arrives in the same cycle the counter expires.
    step("race_c0_rise", 1'b1, 1'b0, 1'b0, 1'b0, e(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
    for (int i = 1; i < int'(Timeout); i++)
      step("race_wait", 1'b1, 1'b0, 1'b0, 1'b0, e(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
    step("race_peer_wins", 1'b1, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    halt_release();
    idle($urandom_range(1, 4), 1'b0);

    // Initiator abort.
    step("abort_rise", 1'b1, 1'b0, 1'b0, 1'b0, e(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
    step("abort_wait", 1'b1, 1'b0, 1'b0, 1'b0, e(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
    step("abort_drop", 1'b0, 1'b0, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    idle(2, 1'b0);

    // Reset during the second HALT cycle.
    step("rh_both",  1'b1, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    step("rh_halt1", 1'b1, 1'b1, 1'b1, 1'b0, e(2'b00, 2'b11, 1'b0, 1'b1, 1'b0));
    step("rh_halt2", 1'b1, 1'b1, 1'b0, 1'b0, e(2'b00, 2'b11, 1'b0, 1'b1, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_dbg", obs, 7'd0);
    for (int i = 0; i < Halt; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_done", obs, 7'd0);
    end
    @(negedge clk);
    core0 = 1'b0; core1 = 1'b0; ack = 1'b0;
    rst = 1'b0;
    idle(3, 1'b0);

    chk("exp_q_drained", 7'(exp_q.size()), 7'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/safe_sync_seq.md
Name: safe_sync_seq

Overview:
- Consumer side of the safe-wrapper control registers.
- Takes the software-driven core0sync/core1sync/intc_ack levels and sequences a dual-core resynchronisation: interrupt the lagging core, wait for the software acknowledge, halt both cores for a fixed window, then release.
- Sits inside the safety wrapper between the control register block and the two cores' interrupt and debug-request inputs.

Parameters:
- TimeoutCycles, 1024, max cycles to wait for the peer core's sync request before flagging an error (>=1).
- HaltCycles, 4, cycles both debug requests are held asserted (>=1).
- CntWidth, $clog2(max(TimeoutCycles,HaltCycles)+1), derived localparam; not overridable.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- core0sync_i  input  1  core 0 sync request level (register q).
- core1sync_i  input  1  core 1 sync request level (register q).
- intc_ack_i  input  1  software acknowledge level (register q).
- err_clr_i  input  1  single-cycle pulse; clears the sticky timeout error.
- intc_o  output  2  per-core sync interrupt; bit i targets core i.
- debug_req_o  output  2  per-core halt request.
- sync_done_o  output  1  one-cycle pulse on release.
- busy_o  output  1  high whenever the FSM is not IDLE.
- timeout_err_o  output  1  sticky timeout flag.

Behaviour:
- One clock, clk_i; reset rst_i is asynchronous and active-high.
- On rst_i assertion, all of the following are 0 immediately: outputs, counter, state=IDLE, input edge registers.
- All outputs are registered (Moore). Each responds one cycle after the state/input change that causes it.
- Rising edges are detected against a registered copy of core0sync_i/core1sync_i.
- IDLE:
  - Rising edge on exactly one sync -> WAIT_PEER; counter=0.
  - Both rise in the same cycle, or both already high -> WAIT_ACK.
  - A level already high at reset release with no edge starts nothing unless both are high.
- WAIT_PEER:
  - intc_o[i]=1 for each core whose sync input is low.
  - Counter increments each cycle.
  - Both syncs high -> WAIT_ACK; intc_o returns to 0.
  - Counter==TimeoutCycles-1 with the peer still low -> ERROR.
  - If the initiating core drops its sync -> IDLE, no error.
  - If the peer goes high in the same cycle the counter expires, the peer wins (-> WAIT_ACK).
- WAIT_ACK:
  - intc_o=0.
  - intc_ack_i high -> HALT; counter=0.
  - No timeout in this state; software owns progress.
- HALT:
  - debug_req_o=2'b11 for exactly HaltCycles cycles, then -> RELEASE.
  - Sync inputs are ignored in this state.
- RELEASE:
  - debug_req_o=0.
  - sync_done_o=1 for the single entry cycle.
  - Stay until core0sync_i, core1sync_i and intc_ack_i are all low, then -> IDLE.
  - This prevents immediate re-trigger from stale levels.
- ERROR:
  - timeout_err_o set; intc_o=0; debug_req_o=0.
  - Next cycle -> RELEASE, which waits for inputs low.
  - timeout_err_o stays set until err_clr_i. err_clr_i in the same cycle as a new set: the set wins.
- busy_o = (state != IDLE).
- Counter saturates; it never wraps.
- Reset mid-sequence (e.g. in HALT) drops debug_req_o combinationally via the async clear. There is no done pulse.

Decomposition:
- safe_sync_seq_pkg holds:
  - the state enum sync_state_e {IDLE, WAIT_PEER, WAIT_ACK, HALT, RELEASE, ERROR}, 3 bits;
  - default constants for TimeoutCycles and HaltCycles.
- One sub-module, safe_sync_edge_det: a per-bit rising-edge detector, parameterised width, async active-high clear. It is instantiated once with width 2.
- FSM and counter stay in the top module.

Test Plan:
- Reset: hold rst_i 3 cycles with all inputs high, then release -> all outputs 0 during reset. After release the FSM reaches WAIT_ACK (both high), busy_o=1, with no intc_o.
- Normal flow:
  - core0sync_i rises at cycle 10 -> intc_o=2'b10 from cycle 11.
  - core1sync_i rises at cycle 20 -> intc_o=0 at 21.
  - intc_ack_i=1 at 25 -> debug_req_o=2'b11 during cycles 26-29 (HaltCycles=4), sync_done_o pulses at 30.
  - All inputs low at 35 -> busy_o=0 at 36.
- Simultaneous request: both syncs rise in one cycle -> intc_o never asserted; direct WAIT_ACK.
- Timeout (TimeoutCycles=8):
  - core1sync_i alone -> intc_o=2'b01 for 8 cycles, then timeout_err_o=1, debug_req_o stays 0.
  - err_clr_i pulse -> timeout_err_o=0 next cycle.
- Peer-at-expiry race: peer sync rises in the same cycle the counter hits TimeoutCycles-1 -> WAIT_ACK entered, timeout_err_o stays 0.
- Abort and reset:
  - Initiator drops sync in WAIT_PEER -> IDLE, no error.
  - Separately, assert rst_i in the 2nd HALT cycle -> debug_req_o=0 without waiting for a clock edge, no sync_done_o pulse.
